// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle control sequencer for the CPU datapath.
// Decodes the latched instruction word and issues one micro-step per clock,
// stalling on the memory handshake and trapping into a sticky fault state
// when memory stays silent for too long.
module mc_control_unit #(
    parameter int DATA_W   = 16,
    parameter int NREG     = 8,    // power of 2, >= 2
    parameter int IMM_W    = 8,    // <= DATA_W
    parameter int WAIT_MAX = 8     // 0 disables the timeout
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr,
    input  logic              mem_ready,
    output logic [NREG-1:0]   rin,
    output logic [NREG-1:0]   rout,
    output logic              a_in,
    output logic              gin,
    output logic              gout,
    output logic              addsub,
    output logic              xorctrl,
    output logic              ctrl_out,
    output logic [DATA_W-1:0] imm_out,
    output logic              addr_ld,
    output logic              ram_addr_sel,
    output logic              ram_out_ctrl,
    output logic              instr_enable,
    output logic              pc_enable,
    output logic              wr_enable,
    output logic              done,
    output logic              halted,
    output logic              fault
);
    localparam int RW = $clog2(NREG);
    // Counter just wide enough to hold WAIT_MAX (at least one bit)
    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW:0] WAIT_LIM = (CW+1)'(WAIT_MAX);

    typedef enum logic [2:0] {FETCH, DECODE, EX1, EX2, EX3, HALT, FAULT} state_t;
    typedef enum logic [2:0] {
        OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_XOR, OP_LD, OP_ST, OP_HALT
    } op_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   wait_cnt_reg, wait_cnt_next;
    logic            mem_wait;

    op_t             op;
    logic [RW-1:0]   rx, ry;
    logic [NREG-1:0] rx_hot, ry_hot;

    // Instruction fields: op in the top three bits, then rx, then ry
    assign op = op_t'(instr[DATA_W-1 -: 3]);
    assign rx = instr[DATA_W-4 -: RW];
    assign ry = instr[DATA_W-4-RW -: RW];

    // One-hot register selects, one comparator per register
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_hot
            assign rx_hot[gi] = (rx == RW'(gi));
            assign ry_hot[gi] = (ry == RW'(gi));
        end
    endgenerate

    // State and wait counter registers, asynchronous reset back to FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= FETCH;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Next-state, wait-timeout and strobe decode; all outputs held at 0 in reset
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;
        mem_wait      = 1'b0;
        rin           = '0;
        rout          = '0;
        a_in          = 1'b0;
        gin           = 1'b0;
        gout          = 1'b0;
        addsub        = 1'b0;
        xorctrl       = 1'b0;
        ctrl_out      = 1'b0;
        imm_out       = '0;
        addr_ld       = 1'b0;
        ram_addr_sel  = 1'b0;
        ram_out_ctrl  = 1'b0;
        instr_enable  = 1'b0;
        pc_enable     = 1'b0;
        wr_enable     = 1'b0;
        done          = 1'b0;
        halted        = 1'b0;
        fault         = 1'b0;

        unique case (state_reg)
            FETCH: begin
                mem_wait = 1'b1;
                if (mem_ready) begin
                    instr_enable = 1'b1;
                    pc_enable    = 1'b1;
                    state_next   = DECODE;
                end
            end
            DECODE: begin
                state_next = (op == OP_HALT) ? HALT : EX1;
            end
            EX1: begin
                unique case (op)
                    OP_MV: begin
                        rout       = ry_hot;
                        rin        = rx_hot;
                        done       = 1'b1;
                        state_next = FETCH;
                    end
                    OP_MVI: begin
                        ctrl_out   = 1'b1;
                        imm_out    = DATA_W'(instr[IMM_W-1:0]);
                        rin        = rx_hot;
                        done       = 1'b1;
                        state_next = FETCH;
                    end
                    OP_ADD, OP_SUB, OP_XOR: begin
                        rout       = rx_hot;
                        a_in       = 1'b1;
                        state_next = EX2;
                    end
                    OP_LD, OP_ST: begin
                        rout       = ry_hot;
                        addr_ld    = 1'b1;
                        state_next = EX2;
                    end
                    default: state_next = FETCH;
                endcase
            end
            EX2: begin
                unique case (op)
                    OP_ADD, OP_SUB, OP_XOR: begin
                        rout       = ry_hot;
                        gin        = 1'b1;
                        addsub     = (op == OP_SUB);
                        xorctrl    = (op == OP_XOR);
                        state_next = EX3;
                    end
                    OP_LD: begin
                        mem_wait     = 1'b1;
                        ram_addr_sel = 1'b1;
                        if (mem_ready) begin
                            ram_out_ctrl = 1'b1;
                            rin          = rx_hot;
                            done         = 1'b1;
                            state_next   = FETCH;
                        end
                    end
                    OP_ST: begin
                        // Write request is level-held until memory accepts it
                        mem_wait     = 1'b1;
                        ram_addr_sel = 1'b1;
                        rout         = rx_hot;
                        wr_enable    = 1'b1;
                        if (mem_ready) begin
                            done       = 1'b1;
                            state_next = FETCH;
                        end
                    end
                    default: state_next = FETCH;
                endcase
            end
            EX3: begin
                gout       = 1'b1;
                rin        = rx_hot;
                done       = 1'b1;
                state_next = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: state_next = FETCH;
        endcase

        // Count consecutive stalled cycles; reaching the limit traps to FAULT
        if (mem_wait && !mem_ready) begin
            wait_cnt_next = wait_cnt_reg + CW'(1);
            if ((WAIT_MAX != 0) && (({1'b0, wait_cnt_reg} + (CW+1)'(1)) == WAIT_LIM)) begin
                state_next    = FAULT;
                wait_cnt_next = '0;
            end
        end

        if (rst) begin
            rin          = '0;
            rout         = '0;
            a_in         = 1'b0;
            gin          = 1'b0;
            gout         = 1'b0;
            addsub       = 1'b0;
            xorctrl      = 1'b0;
            ctrl_out     = 1'b0;
            imm_out      = '0;
            addr_ld      = 1'b0;
            ram_addr_sel = 1'b0;
            ram_out_ctrl = 1'b0;
            instr_enable = 1'b0;
            pc_enable    = 1'b0;
            wr_enable    = 1'b0;
            done         = 1'b0;
            halted       = 1'b0;
            fault        = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed checks of the control sequencer plus a
// random-program sweep over two register-count variants.
module tb_mc_control_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ready;
    logic [15:0] instr;

    int tests_run = 0;
    int fails     = 0;

    // Main instance: NREG=8, short timeout
    logic [7:0]  rin, rout;
    logic        a_in, gin, gout, addsub, xorctrl, ctrl_out;
    logic [15:0] imm_out;
    logic        addr_ld, ram_addr_sel, ram_out_ctrl, instr_enable, pc_enable;
    logic        wr_enable, done, halted, fault;

    // Flag bit positions inside the packed observation vectors
    localparam logic [14:0] F_A_IN   = 15'h4000;
    localparam logic [14:0] F_GIN    = 15'h2000;
    localparam logic [14:0] F_GOUT   = 15'h1000;
    localparam logic [14:0] F_ADDSUB = 15'h0800;
    localparam logic [14:0] F_XOR    = 15'h0400;
    localparam logic [14:0] F_CTRL   = 15'h0200;
    localparam logic [14:0] F_ADDRLD = 15'h0100;
    localparam logic [14:0] F_RAS    = 15'h0080;
    localparam logic [14:0] F_RAMOUT = 15'h0040;
    localparam logic [14:0] F_IE     = 15'h0020;
    localparam logic [14:0] F_PE     = 15'h0010;
    localparam logic [14:0] F_WR     = 15'h0008;
    localparam logic [14:0] F_DONE   = 15'h0004;

    wire [14:0] flags = {a_in, gin, gout, addsub, xorctrl, ctrl_out, addr_ld, ram_addr_sel,
                         ram_out_ctrl, instr_enable, pc_enable, wr_enable, done, halted, fault};
    wire [30:0] so      = {rin, rout, flags};
    wire [46:0] all_out = {rin, rout, imm_out, flags};

    mc_control_unit #(.DATA_W(16), .NREG(8), .IMM_W(8), .WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .rin(rin), .rout(rout), .a_in(a_in), .gin(gin), .gout(gout),
        .addsub(addsub), .xorctrl(xorctrl), .ctrl_out(ctrl_out), .imm_out(imm_out),
        .addr_ld(addr_ld), .ram_addr_sel(ram_addr_sel), .ram_out_ctrl(ram_out_ctrl),
        .instr_enable(instr_enable), .pc_enable(pc_enable), .wr_enable(wr_enable),
        .done(done), .halted(halted), .fault(fault)
    );

    // Sweep instance: NREG=4
    logic [3:0]  s4_rin, s4_rout;
    logic        s4_a_in, s4_gin, s4_gout, s4_addsub, s4_xorctrl, s4_ctrl_out;
    logic [15:0] s4_imm_out;
    logic        s4_addr_ld, s4_ram_addr_sel, s4_ram_out_ctrl, s4_instr_enable, s4_pc_enable;
    logic        s4_wr_enable, s4_done, s4_halted, s4_fault;

    mc_control_unit #(.DATA_W(16), .NREG(4), .IMM_W(8), .WAIT_MAX(8)) dut4 (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .rin(s4_rin), .rout(s4_rout), .a_in(s4_a_in), .gin(s4_gin), .gout(s4_gout),
        .addsub(s4_addsub), .xorctrl(s4_xorctrl), .ctrl_out(s4_ctrl_out), .imm_out(s4_imm_out),
        .addr_ld(s4_addr_ld), .ram_addr_sel(s4_ram_addr_sel), .ram_out_ctrl(s4_ram_out_ctrl),
        .instr_enable(s4_instr_enable), .pc_enable(s4_pc_enable), .wr_enable(s4_wr_enable),
        .done(s4_done), .halted(s4_halted), .fault(s4_fault)
    );

    // Sweep instance: NREG=16
    logic [15:0] s16_rin, s16_rout;
    logic        s16_a_in, s16_gin, s16_gout, s16_addsub, s16_xorctrl, s16_ctrl_out;
    logic [15:0] s16_imm_out;
    logic        s16_addr_ld, s16_ram_addr_sel, s16_ram_out_ctrl, s16_instr_enable, s16_pc_enable;
    logic        s16_wr_enable, s16_done, s16_halted, s16_fault;

    mc_control_unit #(.DATA_W(16), .NREG(16), .IMM_W(8), .WAIT_MAX(8)) dut16 (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .rin(s16_rin), .rout(s16_rout), .a_in(s16_a_in), .gin(s16_gin), .gout(s16_gout),
        .addsub(s16_addsub), .xorctrl(s16_xorctrl), .ctrl_out(s16_ctrl_out), .imm_out(s16_imm_out),
        .addr_ld(s16_addr_ld), .ram_addr_sel(s16_ram_addr_sel), .ram_out_ctrl(s16_ram_out_ctrl),
        .instr_enable(s16_instr_enable), .pc_enable(s16_pc_enable), .wr_enable(s16_wr_enable),
        .done(s16_done), .halted(s16_halted), .fault(s16_fault)
    );

    always #5 clk = ~clk;

    // Encoding for the NREG=8 layout: op[15:13] rx[12:10] ry[9:7] imm[7:0]
    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rx,
                                        input logic [2:0] ry, input logic [7:0] imm);
        return {op, rx, ry, 7'b0} | {8'h00, imm};
    endfunction

    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b0; instr = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; instr = enc(3'd1, 3'd3, 3'd0, 8'h5A);
        #2;
        tests_run++;
        if (all_out !== 47'h0) begin
            $display("FAIL reset_outputs: got %h expected 0", all_out); fails++;
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (all_out !== 47'h0) begin
            $display("FAIL reset_hold: got %h expected 0", all_out); fails++;
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (all_out !== 47'h0) begin
            $display("FAIL reset_fetch_idle: got %h expected 0", all_out); fails++;
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (so !== {16'h0, F_IE | F_PE}) begin
            $display("FAIL reset_first_fetch: got %h expected %h", so, {16'h0, F_IE | F_PE}); fails++;
        end
        @(posedge clk); #1;
        $display("[TB] test_reset complete");
    endtask

    task automatic test_mv_mvi();
        logic [15:0] iv [6];
        logic [30:0] ev [6];
        do_reset();
        for (int i = 0; i < 3; i++) iv[i] = enc(3'd1, 3'd3, 3'd0, 8'h5A);
        for (int i = 3; i < 6; i++) iv[i] = enc(3'd0, 3'd1, 3'd3, 8'h00);
        ev[0] = {16'h0, F_IE | F_PE};
        ev[1] = '0;
        ev[2] = {8'h08, 8'h00, F_CTRL | F_DONE};
        ev[3] = {16'h0, F_IE | F_PE};
        ev[4] = '0;
        ev[5] = {8'h02, 8'h08, F_DONE};
        for (int i = 0; i < 6; i++) begin
            instr = iv[i]; mem_ready = 1'b1;
            @(negedge clk);
            tests_run++;
            if (so !== ev[i]) begin
                $display("FAIL mv_mvi cycle %0d: got %h expected %h", i + 1, so, ev[i]); fails++;
            end
            if (i == 2) begin
                tests_run++;
                if (imm_out !== 16'h005A) begin
                    $display("FAIL mvi_imm: got %h expected 005a", imm_out); fails++;
                end
            end
            @(posedge clk); #1;
        end
        $display("[TB] mvi r3,#5a ; mv r1,r3 complete");
    endtask

    task automatic test_alu();
        logic [30:0] ev [5];
        for (int k = 0; k < 3; k++) begin
            do_reset();
            // k=0: sub r2,r5   k=1: xor r2,r5   k=2: add r6,r0
            if (k == 2) instr = enc(3'd2, 3'd6, 3'd0, 8'h00);
            else        instr = enc((k == 0) ? 3'd3 : 3'd4, 3'd2, 3'd5, 8'h00);
            ev[0] = {16'h0, F_IE | F_PE};
            ev[1] = '0;
            ev[2] = (k == 2) ? {8'h00, 8'h40, F_A_IN} : {8'h00, 8'h04, F_A_IN};
            ev[3] = (k == 2) ? {8'h00, 8'h01, F_GIN} :
                    (k == 0) ? {8'h00, 8'h20, F_GIN | F_ADDSUB} : {8'h00, 8'h20, F_GIN | F_XOR};
            ev[4] = (k == 2) ? {8'h40, 8'h00, F_GOUT | F_DONE} : {8'h04, 8'h00, F_GOUT | F_DONE};
            for (int i = 0; i < 5; i++) begin
                mem_ready = 1'b1;
                @(negedge clk);
                tests_run++;
                if (so !== ev[i]) begin
                    $display("FAIL alu%0d cycle %0d: got %h expected %h", k, i + 1, so, ev[i]); fails++;
                end
                @(posedge clk); #1;
            end
            $display("[TB] alu instr %h complete", instr);
        end
    endtask

    task automatic test_ld_waits();
        // ld r6,[r1]: 3 fetch waits, idle-low ready in DECODE/EX1, 3 EX2 waits
        logic        rv [10];
        logic [30:0] ev [10];
        do_reset();
        instr = enc(3'd5, 3'd6, 3'd1, 8'h00);
        rv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ev[0] = '0; ev[1] = '0; ev[2] = '0;
        ev[3] = {16'h0, F_IE | F_PE};
        ev[4] = '0;
        ev[5] = {8'h00, 8'h02, F_ADDRLD};
        ev[6] = {16'h0, F_RAS}; ev[7] = {16'h0, F_RAS}; ev[8] = {16'h0, F_RAS};
        ev[9] = {8'h40, 8'h00, F_RAS | F_RAMOUT | F_DONE};
        for (int i = 0; i < 10; i++) begin
            mem_ready = rv[i];
            @(negedge clk);
            tests_run++;
            if (so !== ev[i]) begin
                $display("FAIL ld_waits cycle %0d: got %h expected %h", i + 1, so, ev[i]); fails++;
            end
            @(posedge clk); #1;
        end
        $display("[TB] ld r6,[r1] with waits complete");
    endtask

    task automatic test_st_waits();
        logic        rv [7];
        logic [30:0] ev [7];
        do_reset();
        instr = enc(3'd6, 3'd0, 3'd7, 8'h00);
        rv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        ev[0] = {16'h0, F_IE | F_PE};
        ev[1] = '0;
        ev[2] = {8'h00, 8'h80, F_ADDRLD};
        ev[3] = {8'h00, 8'h01, F_RAS | F_WR};
        ev[4] = {8'h00, 8'h01, F_RAS | F_WR};
        ev[5] = {8'h00, 8'h01, F_RAS | F_WR};
        ev[6] = {8'h00, 8'h01, F_RAS | F_WR | F_DONE};
        for (int i = 0; i < 7; i++) begin
            mem_ready = rv[i];
            @(negedge clk);
            tests_run++;
            if (so !== ev[i]) begin
                $display("FAIL st_waits cycle %0d: got %h expected %h", i + 1, so, ev[i]); fails++;
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (so !== {16'h0, F_IE | F_PE}) begin
            $display("FAIL st_next_fetch: got %h expected %h", so, {16'h0, F_IE | F_PE}); fails++;
        end
        @(posedge clk); #1;
        $display("[TB] st r0,[r7] with 3 waits complete");
    endtask

    task automatic test_timeout();
        logic [46:0] exp_v;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            mem_ready = (i >= 8);
            instr = 16'($urandom);
            exp_v = (i < 4) ? 47'h0 : 47'h1;
            @(negedge clk);
            tests_run++;
            if (all_out !== exp_v) begin
                $display("FAIL timeout cycle %0d: got %h expected %h", i + 1, all_out, exp_v); fails++;
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (all_out !== 47'h0) begin
            $display("FAIL fault_reset: got %h expected 0", all_out); fails++;
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b1; instr = '0;
        @(negedge clk);
        tests_run++;
        if (so !== {16'h0, F_IE | F_PE}) begin
            $display("FAIL fault_recover: got %h expected %h", so, {16'h0, F_IE | F_PE}); fails++;
        end
        @(posedge clk); #1;
        $display("[TB] timeout to fault and recovery complete");
    endtask

    task automatic test_halt();
        logic [30:0] ev [2];
        do_reset();
        instr = enc(3'd7, 3'd0, 3'd0, 8'h00);
        ev[0] = {16'h0, F_IE | F_PE};
        ev[1] = '0;
        for (int i = 0; i < 8; i++) begin
            mem_ready = (i < 2) ? 1'b1 : 1'(i);
            if (i >= 2) instr = 16'($urandom);
            @(negedge clk);
            tests_run++;
            if (i < 2) begin
                if (so !== ev[i]) begin
                    $display("FAIL halt cycle %0d: got %h expected %h", i + 1, so, ev[i]); fails++;
                end
            end else begin
                if (all_out !== 47'h2) begin
                    $display("FAIL halt_sticky cycle %0d: got %h expected %h", i + 1, all_out, 47'h2); fails++;
                end
            end
            @(posedge clk); #1;
        end
        $display("[TB] halt sticky complete");
    endtask

    task automatic test_async_reset();
        logic [30:0] ev [3];
        do_reset();
        instr = enc(3'd2, 3'd1, 3'd2, 8'h00);
        ev[0] = {16'h0, F_IE | F_PE};
        ev[1] = '0;
        ev[2] = {8'h00, 8'h02, F_A_IN};
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (so !== ev[i]) begin
                $display("FAIL add_pre cycle %0d: got %h expected %h", i + 1, so, ev[i]); fails++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        tests_run++;
        if (so !== {8'h00, 8'h04, F_GIN}) begin
            $display("FAIL add_ex2: got %h expected %h", so, {8'h00, 8'h04, F_GIN}); fails++;
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (all_out !== 47'h0) begin
            $display("FAIL async_rst_outputs: got %h expected 0", all_out); fails++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (so !== ev[i]) begin
                $display("FAIL add_restart cycle %0d: got %h expected %h", i + 1, so, ev[i]); fails++;
            end
            @(posedge clk); #1;
        end
        $display("[TB] async reset mid-add complete");
    endtask

    task automatic test_sweep();
        int         zeros, d4, d16, cyc;
        logic [2:0] op;
        do_reset();
        zeros = 0;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 6));
            instr = {op, 13'($urandom)};
            d4 = 0; d16 = 0; cyc = 0;
            while (d4 == 0 && cyc < 40) begin
                if (zeros >= 3 || $urandom_range(0, 3) != 0) begin
                    mem_ready = 1'b1; zeros = 0;
                end else begin
                    mem_ready = 1'b0; zeros++;
                end
                @(negedge clk);
                cyc++;
                tests_run++;
                assert ($onehot0(s4_rin) && $onehot0(s4_rout) && !s4_fault && !s4_halted &&
                        ($countones({|s4_rout, s4_gout, s4_ctrl_out, s4_ram_out_ctrl}) <= 1))
                else begin
                    $display("FAIL sweep_nreg4 instr %h: rin %b rout %b bus %b", instr, s4_rin,
                             s4_rout, {s4_gout, s4_ctrl_out, s4_ram_out_ctrl}); fails++;
                end
                tests_run++;
                assert ($onehot0(s16_rin) && $onehot0(s16_rout) && !s16_fault && !s16_halted &&
                        ($countones({|s16_rout, s16_gout, s16_ctrl_out, s16_ram_out_ctrl}) <= 1))
                else begin
                    $display("FAIL sweep_nreg16 instr %h: rin %b rout %b bus %b", instr, s16_rin,
                             s16_rout, {s16_gout, s16_ctrl_out, s16_ram_out_ctrl}); fails++;
                end
                d4  += int'(s4_done);
                d16 += int'(s16_done);
                @(posedge clk); #1;
            end
            tests_run++;
            if (d4 != 1 || d16 != 1) begin
                $display("FAIL sweep_done instr %h: done counts %0d/%0d expected 1/1", instr, d4, d16);
                fails++;
            end
            $display("[TB] sweep #%0d instr %h op %0d cycles %0d", n, instr, op, cyc);
        end
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; instr = '0;
        test_reset();
        test_mv_mvi();
        test_alu();
        test_ld_waits();
        test_st_waits();
        test_timeout();
        test_halt();
        test_async_reset();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
